// File: rtl/w_update_subtractor_stream.sv
// Streaming W = i1 - i2 over a DIM x DIM matrix, LANES elements per beat, row-major, valid/ready.
// Define SUB_SAT_EN for saturating subtraction with a sticky ovf flag; otherwise results wrap.
module w_update_subtractor_stream #(
  parameter int WIDTH = 26,
  parameter int DIM   = 4,
  parameter int LANES = 4
) (
  input  logic                   clk_sub,
  input  logic                   rst_sub,
  input  logic                   en_sub,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] i1_data,
  input  logic [LANES*WIDTH-1:0] i2_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] w_data,
  output logic                   out_last,
  output logic                   mat_done,
  output logic                   ovf
);

  localparam int BEATS = DIM * DIM / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if ((DIM * DIM) % LANES != 0) begin : g_bad_lanes
    $error("w_update_subtractor_stream: DIM*DIM must be a multiple of LANES");
  end

  logic [CW-1:0]          cnt;
  logic [LANES*WIDTH-1:0] res;
  logic                   accept;
  logic                   out_hs;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

`ifdef SUB_SAT_EN
  logic [WIDTH:0]   diff;
  logic [LANES-1:0] clamp;

  always_comb begin
    res   = '0;
    clamp = '0;
    diff  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (!en_sub) begin
        res[k*WIDTH +: WIDTH] = i2_data[k*WIDTH +: WIDTH];
      end else begin
        diff = {i1_data[k*WIDTH+WIDTH-1], i1_data[k*WIDTH +: WIDTH]}
             - {i2_data[k*WIDTH+WIDTH-1], i2_data[k*WIDTH +: WIDTH]};
        // Overflow exactly when the extra sign bit disagrees with the WIDTH-bit sign.
        if (diff[WIDTH] != diff[WIDTH-1]) begin
          clamp[k] = 1'b1;
          res[k*WIDTH +: WIDTH] = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          res[k*WIDTH +: WIDTH] = diff[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_sub) begin
    if (rst_sub) begin
      ovf <= 1'b0;
    end else if (accept && (|clamp)) begin
      ovf <= 1'b1;
    end
  end
`else
  // Low WIDTH bits of the WIDTH+1 difference equal a plain WIDTH-bit subtraction.
  always_comb begin
    res = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      res[k*WIDTH +: WIDTH] = en_sub ? (i1_data[k*WIDTH +: WIDTH] - i2_data[k*WIDTH +: WIDTH])
                                     : i2_data[k*WIDTH +: WIDTH];
    end
  end

  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk_sub) begin
    if (rst_sub) begin
      out_valid <= 1'b0;
      w_data    <= '0;
      out_last  <= 1'b0;
      mat_done  <= 1'b0;
      cnt       <= '0;
    end else begin
      mat_done <= out_hs && out_last;
      if (accept) begin
        w_data    <= res;
        out_valid <= 1'b1;
        out_last  <= (cnt == LAST_CNT);
        cnt       <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_w_update_subtractor_stream.sv
// Bench for w_update_subtractor_stream: vector table, directed flow-control sequences and
// randomized traffic on a DIM=3/LANES=3 instance, all checked against a queue-based model.
module tb_w_update_subtractor_stream;
  localparam int W = 26;
  localparam logic [W-1:0] MAXP = 26'h1FFFFFF;
  localparam logic [W-1:0] MINN = 26'h2000000;
  localparam logic [W-1:0] NEG1 = 26'h3FFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, in_valid, out_ready, sel, mon_en;
  logic [4*W-1:0] i1, i2;

  logic rdy4, ov4, last4, done4, ovf4;
  logic [4*W-1:0] w4;
  logic rdy3, ov3, last3, done3, ovf3;
  logic [3*W-1:0] w3;

  w_update_subtractor_stream #(.WIDTH(W), .DIM(4), .LANES(4)) dut (
    .clk_sub(clk), .rst_sub(rst), .en_sub(en), .in_valid(in_valid), .in_ready(rdy4),
    .i1_data(i1), .i2_data(i2), .out_valid(ov4), .out_ready(out_ready), .w_data(w4),
    .out_last(last4), .mat_done(done4), .ovf(ovf4));

  w_update_subtractor_stream #(.WIDTH(W), .DIM(3), .LANES(3)) dut3 (
    .clk_sub(clk), .rst_sub(rst), .en_sub(en), .in_valid(in_valid), .in_ready(rdy3),
    .i1_data(i1[3*W-1:0]), .i2_data(i2[3*W-1:0]), .out_valid(ov3), .out_ready(out_ready),
    .w_data(w3), .out_last(last3), .mat_done(done3), .ovf(ovf3));

  logic           m_valid, m_ready, m_last, m_done, m_ovf;
  logic [4*W-1:0] m_w;
  assign m_valid = sel ? ov3   : ov4;
  assign m_ready = sel ? rdy3  : rdy4;
  assign m_last  = sel ? last3 : last4;
  assign m_done  = sel ? done3 : done4;
  assign m_ovf   = sel ? ovf3  : ovf4;
  assign m_w     = sel ? {{W{1'b0}}, w3} : w4;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic logic [W-1:0] ref_lane(input bit e, input logic [W-1:0] a,
                                            input logic [W-1:0] b, output bit clamped);
    longint d;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (W-1)) - 1;
    minv = -(longint'(1) <<< (W-1));
    clamped = 1'b0;
    if (!e) return b;
    d = longint'($signed(a)) - longint'($signed(b));
`ifdef SUB_SAT_EN
    if (d > maxv) begin d = maxv; clamped = 1'b1; end
    else if (d < minv) begin d = minv; clamped = 1'b1; end
`endif
    return d[W-1:0];
  endfunction

  typedef struct { logic [4*W-1:0] w; bit last; } beat_t;
  beat_t q[$];
  int mcnt = 0;
  int done_model = 0;
  int done_seen = 0;
  bit exp_done = 1'b0;
  bit exp_ovf = 1'b0;

  always @(negedge clk) if (mon_en) begin
    int    lanes;
    int    beats;
    bit    qe, acc, cl, any;
    beat_t b;
    lanes = sel ? 3 : 4;
    beats = sel ? 3 : 4;
    qe = (q.size() == 0);
    chk("out_valid", m_valid, !qe);
    chk("in_ready", m_ready, qe || out_ready);
    if (!qe) begin
      chk("w_data", m_w, q[0].w);
      chk("out_last", m_last, q[0].last);
    end
    chk("mat_done", m_done, exp_done);
    chk("ovf", m_ovf, exp_ovf);
    if (m_done) done_seen++;
    if (rst) begin
      q.delete();
      mcnt = 0;
      exp_done = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      acc = in_valid && (qe || out_ready);
      exp_done = 1'b0;
      if (!qe && out_ready) begin
        exp_done = q[0].last;
        if (q[0].last) done_model++;
        void'(q.pop_front());
      end
      if (acc) begin
        b.w = '0;
        any = 1'b0;
        for (int k = 0; k < lanes; k++) begin
          b.w[k*W +: W] = ref_lane(en, i1[k*W +: W], i2[k*W +: W], cl);
          any = any | cl;
        end
        b.last = (mcnt == beats - 1);
        mcnt = (mcnt + 1) % beats;
        if (any) exp_ovf = 1'b1;
        q.push_back(b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < 4; k++) begin
      i1[k*W +: W] = a;
      i2[k*W +: W] = b;
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return MAXP;
      1: return MINN;
      2: return NEG1;
      default: return r[W-1:0];
    endcase
  endfunction

  typedef struct { bit en; logic [W-1:0] i1; logic [W-1:0] i2; logic [W-1:0] w; } vec_t;

  initial begin
    vec_t vecs[8];
    logic [4*W-1:0] held;
    int d0;
    bit sat;
`ifdef SUB_SAT_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    vecs[0] = '{1'b1, 26'd100, 26'd30, 26'd70};
    vecs[1] = '{1'b1, -26'sd50, 26'd20, -26'sd70};
    vecs[2] = '{1'b0, 26'd5, -26'sd7, -26'sd7};
    vecs[3] = '{1'b0, MAXP, MINN, MINN};
    vecs[4] = '{1'b1, MAXP, NEG1, sat ? MAXP : MINN};
    vecs[5] = '{1'b1, MINN, 26'd1, sat ? MINN : MAXP};
    vecs[6] = '{1'b1, 26'd0, MINN, sat ? MAXP : MINN};
    vecs[7] = '{1'b1, NEG1, NEG1, 26'd0};

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0; mon_en = 1'b0;
    i1 = '0; i2 = '0;
    step();
    mon_en = 1'b1;
    chk("rst_w_data", w4, '0);
    chk("rst_out_valid", ov4, 1'b0);

    // Four beats of 100 - 30 at full throughput.
    rst = 1'b0; en = 1'b1; in_valid = 1'b1;
    set_lanes(26'd100, 26'd30);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t1_w", w4, {4{26'd70}});
      chk("t1_last", last4, j == 3);
    end
    in_valid = 1'b0;
    step();
    step();
    chk("t1_done_count", done_seen, 1);

    // Vector table: bypass, ordinary and overflowing differences.
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en;
      set_lanes(vecs[i].i1, vecs[i].i2);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("vec_w", w4, {4{vecs[i].w}});
      if (i == 3) chk("ovf_after_bypass", ovf4, 1'b0);
      step();
    end
    chk("ovf_sticky", ovf4, sat);

    // Backpressure: output held for 3 cycles, then released.
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    set_lanes(26'd1000, 26'd1);
    step();
    held = w4;
    chk("bp_first", held, {4{26'd999}});
    for (int j = 0; j < 3; j++) begin
      set_lanes(26'd2000 + 26'(j), 26'd1);
      step();
      chk("bp_in_ready", rdy4, 1'b0);
      chk("bp_hold", w4, held);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      set_lanes(26'd3000 + 26'(j), 26'd1);
      step();
      chk("bp_release_w", w4, {4{26'd2999 + 26'(j)}});
      chk("bp_last", last4, j == 2);
    end
    in_valid = 1'b0;
    step();
    step();

    // Reset after three beats of a matrix: counter restarts, no mat_done for aborted matrix.
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b1;
    set_lanes(26'd7, 26'd3);
    repeat (3) step();
    rst = 1'b1; in_valid = 1'b0;
    d0 = done_seen;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", ov4, 1'b0);
    in_valid = 1'b1;
    set_lanes(26'd9, 26'd4);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("rst_mid_last", last4, j == 3);
    end
    in_valid = 1'b0;
    step();
    step();
    chk("rst_mid_done", done_seen - d0, 1);

    // Randomized traffic on the DIM=3, LANES=3 instance.
    rst = 1'b1;
    step();
    sel = 1'b1;
    step();
    rst = 1'b0;
    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      en        = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        i1[k*W +: W] = rand_val();
        i2[k*W +: W] = rand_val();
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("rand_mat_count", done_seen, done_model);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
